// File: rtl/sd_spi_responder.sv
// sd_spi_responder: card side of an SPI-mode SD link.
// Oversamples SCK/CS_n/MOSI on i_clk, decodes 6-byte commands, answers with
// R1/R3/R7 on MISO and accepts CMD24 single-block writes, streaming each block
// byte to a sink together with its index and the block address.
//
// Ports:
//   i_clk, i_rst          system clock, synchronous active-high reset
//   i_spi_clk/cs_n/mosi   asynchronous SPI inputs from the controller (mode 0)
//   o_spi_miso            card-to-controller data, 1 when idle/deselected
//   o_wr_data/idx/valid   received block byte stream
//   o_blk_addr            CMD24 argument, latched at command decode
//   o_blk_done/abort      end-of-block and CS-abort strobes
//   o_card_idle           idle flag reported as R1 bit 0
//   o_dbg_state           current FSM state
//
// Stream semantics: o_wr_valid is a push-only one-cycle strobe with no ready;
// o_wr_data and o_wr_idx are valid exactly in that cycle and the sink must
// take every byte presented.
module sd_spi_responder #(
  parameter int ACMD41_RETRIES = 2,
  parameter int BUSY_BYTES     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_spi_clk,
  input  logic        i_spi_cs_n,
  input  logic        i_spi_mosi,
  output logic        o_spi_miso,
  output logic [7:0]  o_wr_data,
  output logic        o_wr_valid,
  output logic [8:0]  o_wr_idx,
  output logic [31:0] o_blk_addr,
  output logic        o_blk_done,
  output logic        o_blk_abort,
  output logic        o_card_idle,
  output logic [3:0]  o_dbg_state
);

  localparam logic [3:0] S_CMD   = 4'd0;
  localparam logic [3:0] S_ARG   = 4'd1;
  localparam logic [3:0] S_NCR   = 4'd2;
  localparam logic [3:0] S_RESP  = 4'd3;
  localparam logic [3:0] S_TOKEN = 4'd4;
  localparam logic [3:0] S_DATA  = 4'd5;
  localparam logic [3:0] S_CRC   = 4'd6;
  localparam logic [3:0] S_DRESP = 4'd7;
  localparam logic [3:0] S_BUSY  = 4'd8;

  // Input synchronizers
  logic [1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_prev;
  logic       sck_rise, sck_fall, cs_off;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b11;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], i_spi_clk};
      cs_sync   <= {cs_sync[0], i_spi_cs_n};
      mosi_sync <= {mosi_sync[0], i_spi_mosi};
      sck_prev  <= sck_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign sck_fall = ~sck_sync[1] & sck_prev;
  assign cs_off   = cs_sync[1];

  // Byte framing
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] tx_next;    // byte the FSM wants in the next byte slot
  logic       rx_byte;
  logic [7:0] rx_data;

  // A byte completes on the 8th rise; the CS check makes a simultaneous
  // deselect discard the byte.
  assign rx_byte = sck_rise & ~cs_off & (bit_cnt == 3'd7);
  assign rx_data = {rx_shift, mosi_sync[1]};

  always_ff @(posedge i_clk) begin
    if (i_rst || cs_off) begin
      bit_cnt    <= 3'd0;
      rx_shift   <= 7'd0;
      tx_shift   <= 8'hFF;
      o_spi_miso <= 1'b1;
    end else begin
      if (sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= {rx_shift[5:0], mosi_sync[1]};
      end
      if (sck_fall) begin
        // bit_cnt == 0 on a fall means the 8th rise just happened: byte boundary
        if (bit_cnt == 3'd0) begin
          o_spi_miso <= tx_next[7];
          tx_shift   <= {tx_next[6:0], 1'b1};
        end else begin
          o_spi_miso <= tx_shift[7];
          tx_shift   <= {tx_shift[6:0], 1'b1};
        end
      end
    end
  end

  // Command / data FSM
  logic [3:0]  state;
  logic [5:0]  cmd_idx;
  logic [31:0] arg;
  logic [2:0]  arg_cnt;
  logic [39:0] resp_sr;    // pending response bytes, first byte in [39:32]
  logic [2:0]  resp_left;
  logic        go_token;
  logic [8:0]  data_cnt;
  logic        crc_cnt;
  logic [7:0]  busy_cnt;
  logic [7:0]  acmd_cnt;
  logic        app;
  logic [7:0]  r1_idle;

  assign r1_idle     = {7'd0, o_card_idle};
  assign o_dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_CMD;
      cmd_idx     <= 6'd0;
      arg         <= 32'd0;
      arg_cnt     <= 3'd0;
      resp_sr     <= 40'd0;
      resp_left   <= 3'd0;
      go_token    <= 1'b0;
      data_cnt    <= 9'd0;
      crc_cnt     <= 1'b0;
      busy_cnt    <= 8'd0;
      acmd_cnt    <= 8'd0;
      app         <= 1'b0;
      tx_next     <= 8'hFF;
      o_card_idle <= 1'b1;
      o_wr_data   <= 8'd0;
      o_wr_valid  <= 1'b0;
      o_wr_idx    <= 9'd0;
      o_blk_addr  <= 32'd0;
      o_blk_done  <= 1'b0;
      o_blk_abort <= 1'b0;
    end else begin
      o_wr_valid  <= 1'b0;
      o_blk_done  <= 1'b0;
      o_blk_abort <= 1'b0;
      if (cs_off) begin
        // Only an interrupted block is reported; state is CMD next cycle so
        // the abort strobe fires once per deselect.
        if (state == S_TOKEN || state == S_DATA || state == S_CRC)
          o_blk_abort <= 1'b1;
        state   <= S_CMD;
        tx_next <= 8'hFF;
        arg_cnt <= 3'd0;
      end else if (rx_byte) begin
        case (state)
          S_CMD: begin
            if (rx_data[7:6] == 2'b01) begin
              cmd_idx <= rx_data[5:0];
              arg_cnt <= 3'd0;
              state   <= S_ARG;
            end
          end
          S_ARG: begin
            if (arg_cnt == 3'd4) begin
              // CRC byte received: the command takes effect here
              state     <= S_NCR;
              app       <= (cmd_idx == 6'd55);
              go_token  <= 1'b0;
              resp_left <= 3'd1;
              resp_sr   <= {8'h04 | r1_idle, 32'hFFFF_FFFF};
              case (cmd_idx)
                6'd0: begin
                  resp_sr     <= {8'h01, 32'hFFFF_FFFF};
                  o_card_idle <= 1'b1;
                  acmd_cnt    <= 8'd0;
                end
                6'd8: begin
                  resp_sr   <= {r1_idle, 8'h00, 8'h00, {4'h0, arg[11:8]}, arg[7:0]};
                  resp_left <= 3'd5;
                end
                6'd55: resp_sr <= {r1_idle, 32'hFFFF_FFFF};
                6'd41: begin
                  if (app) begin
                    if (acmd_cnt < 8'(ACMD41_RETRIES)) begin
                      resp_sr  <= {8'h01, 32'hFFFF_FFFF};
                      acmd_cnt <= acmd_cnt + 8'd1;
                    end else begin
                      resp_sr     <= {8'h00, 32'hFFFF_FFFF};
                      o_card_idle <= 1'b0;
                    end
                  end
                end
                6'd58: begin
                  resp_sr   <= {r1_idle, 8'hC0, 8'hFF, 8'h80, 8'h00};
                  resp_left <= 3'd5;
                end
                6'd24: begin
                  if (o_card_idle) begin
                    resp_sr <= {8'h05, 32'hFFFF_FFFF};
                  end else begin
                    resp_sr    <= {8'h00, 32'hFFFF_FFFF};
                    o_blk_addr <= arg;
                    go_token   <= 1'b1;
                  end
                end
                default: ;
              endcase
            end else begin
              arg     <= {arg[23:0], rx_data};
              arg_cnt <= arg_cnt + 3'd1;
            end
          end
          S_NCR, S_RESP: begin
            // The NCR slot ends by queueing the first response byte, so
            // response bytes follow back to back.
            if (state == S_NCR || resp_left != 3'd0) begin
              tx_next   <= resp_sr[39:32];
              resp_sr   <= {resp_sr[31:0], 8'hFF};
              resp_left <= resp_left - 3'd1;
              state     <= S_RESP;
            end else begin
              tx_next <= 8'hFF;
              state   <= go_token ? S_TOKEN : S_CMD;
            end
          end
          S_TOKEN: begin
            if (rx_data == 8'hFE) begin
              data_cnt <= 9'd0;
              state    <= S_DATA;
            end
          end
          S_DATA: begin
            o_wr_valid <= 1'b1;
            o_wr_data  <= rx_data;
            o_wr_idx   <= data_cnt;
            if (data_cnt == 9'd511) begin
              crc_cnt <= 1'b0;
              state   <= S_CRC;
            end else begin
              data_cnt <= data_cnt + 9'd1;
            end
          end
          S_CRC: begin
            if (crc_cnt) begin
              o_blk_done <= 1'b1;
              tx_next    <= 8'h05;
              state      <= S_DRESP;
            end else begin
              crc_cnt <= 1'b1;
            end
          end
          S_DRESP: begin
            tx_next  <= 8'h00;
            busy_cnt <= 8'd0;
            state    <= S_BUSY;
          end
          S_BUSY: begin
            if (busy_cnt == 8'(BUSY_BYTES - 1)) begin
              tx_next <= 8'hFF;
              state   <= S_CMD;
            end else begin
              busy_cnt <= busy_cnt + 8'd1;
            end
          end
          default: state <= S_CMD;
        endcase
      end
    end
  end

endmodule
